// File: rtl/demosaic_wsum_pkg.sv
// Shared defaults, FSM state type and counter-width helper for the weighted-sum normaliser.
package demosaic_wsum_pkg;

  localparam int DEF_IN_W      = 24;
  localparam int DEF_ACC_W     = 27;
  localparam int DEF_MAX_TERMS = 8;
  localparam int DEF_SHIFT     = 12;
  localparam int DEF_OUT_W     = 10;

  typedef enum logic {IDLE, ACCUM} state_t;

  function automatic int cnt_w(input int max_terms);
    return $clog2(max_terms);
  endfunction

  localparam int DEF_CNT_W = cnt_w(DEF_MAX_TERMS);

endpackage

// File: rtl/demosaic_wsum_rndsat.sv
// Round-half-up, right-shift by the weight fraction width, and clamp to pixel width.
// Purely combinational; clamp flags that the rounded value exceeded the pixel range.
module demosaic_wsum_rndsat
  import demosaic_wsum_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int SHIFT = DEF_SHIFT,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic [ACC_W-1:0] sum,
  output logic [OUT_W-1:0] out_data,
  output logic             clamp
);

  localparam logic [ACC_W:0] HALF = (ACC_W+1)'(1) << (SHIFT - 1);
  localparam logic [ACC_W:0] MAXV = ((ACC_W+1)'(1) << OUT_W) - (ACC_W+1)'(1);

  logic [ACC_W:0] rsum;
  logic [ACC_W:0] r;

  // One extra bit so adding the half-LSB can never wrap.
  always_comb begin
    rsum     = {1'b0, sum} + HALF;
    r        = rsum >> SHIFT;
    clamp    = (r > MAXV);
    out_data = clamp ? '1 : r[OUT_W-1:0];
  end

endmodule

// File: rtl/demosaic_wsum_norm.sv
// Accumulates weighted products per group, normalises on close; result 1 cycle after closing beat.
// in_ready drops only while a result is held and out_ready is low; full throughput otherwise.
module demosaic_wsum_norm
  import demosaic_wsum_pkg::*;
#(
  parameter int IN_W      = DEF_IN_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int MAX_TERMS = DEF_MAX_TERMS,
  parameter int SHIFT     = DEF_SHIFT,
  parameter int OUT_W     = DEF_OUT_W
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf
);

  localparam int CNT_W = cnt_w(MAX_TERMS);

  if (MAX_TERMS < 2) begin : g_bad_terms
    $error("MAX_TERMS must be at least 2");
  end
  if (SHIFT < 1 || SHIFT > ACC_W - OUT_W) begin : g_bad_shift
    $error("SHIFT out of range 1..ACC_W-OUT_W");
  end
  if ((longint'(1) << ACC_W) <= longint'(MAX_TERMS) * ((longint'(1) << IN_W) - 1))
  begin : g_bad_acc
    $error("ACC_W too narrow for MAX_TERMS full-scale products");
  end

  state_t             state, state_nx;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   sum;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W:0]     cnt_inc;
  logic               accept;
  logic               force_cls;
  logic               close;
  logic               clamp;
  logic [OUT_W-1:0]   rs_data;

  assign in_ready  = ap_rst_n && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign cnt_inc   = {1'b0, cnt} + (CNT_W+1)'(1);
  // A flagged last beat on the final slot is a normal close, not a forced one.
  assign force_cls = !in_last && (cnt_inc == (CNT_W+1)'(MAX_TERMS));
  assign close     = accept && (in_last || force_cls);
  assign sum       = acc + ACC_W'(in_data);

  demosaic_wsum_rndsat #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W)
  ) u_rndsat (
    .sum      (sum),
    .out_data (rs_data),
    .clamp    (clamp)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && !close) state_nx = ACCUM;
      ACCUM:   if (close)            state_nx = IDLE;
      default:                       state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      if (close) begin
        // Overwrites any result draining on this same edge.
        acc       <= '0;
        cnt       <= '0;
        out_valid <= 1'b1;
        out_data  <= rs_data;
        out_ovf   <= clamp || force_cls;
      end else begin
        if (accept) begin
          acc <= sum;
          cnt <= cnt_inc[CNT_W-1:0];
        end
        if (out_valid && out_ready) out_valid <= 1'b0;
      end
    end
  end

endmodule
